// File: rtl/chirp_gen_core.sv
// chirp_gen_core: parametrised LoRa-style chirp generator.
// Accepts a chirp configuration over a valid/ready handshake, then emits a
// phase-continuous up- or down-chirp as phase MSB samples, one per divider
// period, and finishes with an active-low one-cycle done pulse.
module chirp_gen_core #(
   parameter int unsigned PHASE_WIDTH = 32,
   parameter int unsigned SF_MIN      = 6,
   parameter int unsigned SF_MAX      = 12,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DIV_WIDTH   = 7,
   parameter int unsigned NSYM_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cfg_valid,
   output logic                  o_cfg_ready,
   input  logic [3:0]            i_cfg_sf,
   input  logic [SF_MAX-1:0]     i_cfg_sym,
   input  logic                  i_cfg_down,
   input  logic [NSYM_WIDTH-1:0] i_cfg_nsym,
   input  logic [DIV_WIDTH-1:0]  i_cfg_div,
   input  logic                  i_abort,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_done_n
);

   localparam int unsigned SHW = $clog2(PHASE_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;

   // Latched configuration
   logic [3:0]              sf_q;
   logic [SF_MAX-1:0]       sym_q;
   logic                    down_q;
   logic [NSYM_WIDTH-1:0]   nsym_q;
   logic [DIV_WIDTH-1:0]    div_q;

   // Running state
   logic [PHASE_WIDTH-1:0]  phase;
   logic [SF_MAX-1:0]       n;
   logic [NSYM_WIDTH-1:0]   sym_cnt;
   logic [DIV_WIDTH-1:0]    div_cnt;

   // Acceptance-side decode
   logic [3:0]              sf_clamped;
   logic [SF_MAX-1:0]       sym_masked;

   // Run-side decode
   logic [SF_MAX-1:0]       n_mask;
   logic [SF_MAX-1:0]       k;
   logic [PHASE_WIDTH-1:0]  half_n;
   logic [SHW-1:0]          shamt;
   logic [PHASE_WIDTH-1:0]  f_up;
   logic [PHASE_WIDTH-1:0]  f_step;
   logic                    tick;
   logic                    last_n;
   logic                    last_sym;

   assign o_cfg_ready = (state == IDLE);

   // Clamp the offered spreading factor and mask the symbol to SF bits
   always_comb begin
      sf_clamped = i_cfg_sf;
      if (i_cfg_sf < 4'(SF_MIN)) begin
         sf_clamped = 4'(SF_MIN);
      end else if (i_cfg_sf > 4'(SF_MAX)) begin
         sf_clamped = 4'(SF_MAX);
      end
      sym_masked = i_cfg_sym & ~({SF_MAX{1'b1}} << sf_clamped);
   end

   // Frequency step for the current sample: (k - N/2) scaled to the phase MSBs
   always_comb begin
      n_mask   = ~({SF_MAX{1'b1}} << sf_q);
      k        = (n + sym_q) & n_mask;
      half_n   = PHASE_WIDTH'(1) << (sf_q - 4'd1);
      shamt    = SHW'(PHASE_WIDTH) - SHW'(sf_q);
      f_up     = (PHASE_WIDTH'(k) - half_n) << shamt;
      f_step   = down_q ? ('0 - f_up) : f_up;
      tick     = (div_cnt == div_q);
      last_n   = (n == n_mask);
      last_sym = (sym_cnt == nsym_q);
   end

   // Control FSM, phase accumulator and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         sf_q     <= 4'(SF_MIN);
         sym_q    <= '0;
         down_q   <= 1'b0;
         nsym_q   <= '0;
         div_q    <= '0;
         phase    <= '0;
         n        <= '0;
         sym_cnt  <= '0;
         div_cnt  <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_done_n <= 1'b1;
      end else begin
         o_valid  <= 1'b0;
         o_done_n <= 1'b1;
         case (state)
            IDLE: begin
               if (i_cfg_valid) begin
                  sf_q    <= sf_clamped;
                  sym_q   <= sym_masked;
                  down_q  <= i_cfg_down;
                  nsym_q  <= i_cfg_nsym;
                  div_q   <= i_cfg_div;
                  phase   <= '0;
                  n       <= '0;
                  sym_cnt <= '0;
                  div_cnt <= '0;
                  o_busy  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               // Abort takes priority over a coinciding tick, including the final one
               if (i_abort) begin
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end else if (tick) begin
                  div_cnt <= '0;
                  o_data  <= phase[PHASE_WIDTH-1 -: DATA_WIDTH];
                  phase   <= phase + f_step;
                  o_valid <= 1'b1;
                  if (last_n) begin
                     n       <= '0;
                     sym_cnt <= sym_cnt + NSYM_WIDTH'(1);
                     if (last_sym) begin
                        o_busy <= 1'b0;
                        state  <= DONE;
                     end
                  end else begin
                     n <= n + SF_MAX'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_WIDTH'(1);
               end
            end
            DONE: begin
               // Registered, so the low pulse lands in the cycle after the last sample
               o_done_n <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chirp_gen_core.sv
// Directed self-checking bench for chirp_gen_core.
module tb_chirp_gen_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [3:0]  cfg_sf;
   logic [11:0] cfg_sym;
   logic        cfg_down;
   logic [7:0]  cfg_nsym;
   logic [6:0]  cfg_div;
   logic        abort;
   logic [7:0]  data;
   logic        valid;
   logic        busy;
   logic        done_n;

   chirp_gen_core #(
      .PHASE_WIDTH(32),
      .SF_MIN     (6),
      .SF_MAX     (12),
      .DATA_WIDTH (8),
      .DIV_WIDTH  (7),
      .NSYM_WIDTH (8)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_cfg_valid(cfg_valid),
      .o_cfg_ready(cfg_ready),
      .i_cfg_sf   (cfg_sf),
      .i_cfg_sym  (cfg_sym),
      .i_cfg_down (cfg_down),
      .i_cfg_nsym (cfg_nsym),
      .i_cfg_div  (cfg_div),
      .i_abort    (abort),
      .o_data     (data),
      .o_valid    (valid),
      .o_busy     (busy),
      .o_done_n   (done_n)
   );

   always #5 clk = ~clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Cycle counter and output monitor
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [7:0] samp[$];
   int         vtime[$];
   int         done_time[$];
   int         done_cnt = 0;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         samp.push_back(data);
         vtime.push_back(cyc);
      end
      if (done_n === 1'b0) begin
         done_cnt++;
         done_time.push_back(cyc);
      end
   end

   // Expected SF=6 sample j: phase/2^26 = j(j-1)/2 + (sym-32)j, top 8 bits = 4*(that mod 64)
   function automatic logic [7:0] model6(input int j, input int sym, input bit down);
      int x;
      x = (j * (j - 1)) / 2 + (sym - 32) * j;
      if (down) x = -x;
      x = ((x % 64) + 64) % 64;
      return 8'(x * 4);
   endfunction

   task automatic clear_mon();
      samp.delete();
      vtime.delete();
      done_time.delete();
      done_cnt = 0;
   endtask

   task automatic apply_cfg(input logic [3:0] sf, input logic [11:0] sym, input logic down,
                            input logic [7:0] nsym, input logic [6:0] div, output int acc);
      @(negedge clk);
      cfg_sf    = sf;
      cfg_sym   = sym;
      cfg_down  = down;
      cfg_nsym  = nsym;
      cfg_div   = div;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      acc       = cyc;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt >= target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_samples(input int target, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         #1;
         if (samp.size() >= target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("sample_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int acc;
      int acc_list[$];
      int cnt;

      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_sf    = 4'd6;
      cfg_sym   = '0;
      cfg_down  = 1'b0;
      cfg_nsym  = '0;
      cfg_div   = '0;
      abort     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",   32'(data),      32'h0);
      check("rst_valid",  32'(valid),     32'h0);
      check("rst_busy",   32'(busy),      32'h0);
      check("rst_done_n", 32'(done_n),    32'h1);
      check("rst_ready",  32'(cfg_ready), 32'h1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Up-chirp SF=6, sym=0, two symbols, div=0
      clear_mon();
      apply_cfg(4'd6, 12'd0, 1'b0, 8'd1, 7'd0, acc);
      check("up_busy", 32'(busy), 32'h1);
      check("up_ready", 32'(cfg_ready), 32'h0);
      wait_done(1, 400);
      check("up_count", 32'(samp.size()), 32'd128);
      if (samp.size() == 128) begin
         for (int j = 0; j < 128; j++) check($sformatf("up_s%0d", j), 32'(samp[j]), 32'(model6(j, 0, 1'b0)));
         check("up_first_t", 32'(vtime[0]), 32'(acc + 1));
         check("up_span", 32'(vtime[127] - vtime[0]), 32'd127);
         if (done_time.size() > 0) check("up_done_t", 32'(done_time[0]), 32'(vtime[127] + 1));
      end
      repeat (3) @(negedge clk);
      check("up_done_cnt", 32'(done_cnt), 32'd1);
      check("up_idle_busy", 32'(busy), 32'h0);
      check("up_idle_ready", 32'(cfg_ready), 32'h1);

      // Down-chirp SF=6, sym=0
      clear_mon();
      apply_cfg(4'd6, 12'd0, 1'b1, 8'd0, 7'd0, acc);
      wait_done(1, 300);
      check("dn_count", 32'(samp.size()), 32'd64);
      if (samp.size() == 64) begin
         check("dn_s0", 32'(samp[0]), 32'h00);
         check("dn_s1", 32'(samp[1]), 32'h80);
         check("dn_s2", 32'(samp[2]), 32'hFC);
         for (int j = 3; j < 64; j++) check($sformatf("dn_s%0d", j), 32'(samp[j]), 32'(model6(j, 0, 1'b1)));
      end

      // Up-chirp with symbol offset; 0x041 masks to 1 at SF=6
      clear_mon();
      apply_cfg(4'd6, 12'h041, 1'b0, 8'd0, 7'd0, acc);
      wait_done(1, 300);
      check("sym_count", 32'(samp.size()), 32'd64);
      if (samp.size() == 64) begin
         check("sym_s1", 32'(samp[1]), 32'h84);
         for (int j = 0; j < 64; j++) check($sformatf("sym_s%0d", j), 32'(samp[j]), 32'(model6(j, 1, 1'b0)));
      end

      // SF=3 clamps to 6, div=3; offered config during RUN must be ignored
      clear_mon();
      apply_cfg(4'd3, 12'd0, 1'b0, 8'd0, 7'd3, acc);
      @(negedge clk);
      cfg_sf    = 4'd12;
      cfg_nsym  = 8'd5;
      cfg_valid = 1'b1;
      repeat (30) @(negedge clk);
      check("run_ready", 32'(cfg_ready), 32'h0);
      cfg_valid = 1'b0;
      wait_done(1, 1000);
      check("div_count", 32'(samp.size()), 32'd64);
      if (samp.size() == 64) begin
         check("div_first_t", 32'(vtime[0]), 32'(acc + 4));
         check("div_gap", 32'(vtime[1] - vtime[0]), 32'd4);
         check("div_span", 32'(vtime[63] - vtime[0]), 32'd252);
         check("div_s2", 32'(samp[2]), 32'h04);
      end
      repeat (5) @(negedge clk);
      check("div_done_cnt", 32'(done_cnt), 32'd1);

      // SF=15 clamps to 12
      clear_mon();
      apply_cfg(4'd15, 12'd0, 1'b0, 8'd0, 7'd0, acc);
      wait_done(1, 5000);
      check("sf12_count", 32'(samp.size()), 32'd4096);
      if (samp.size() == 4096) begin
         check("sf12_s1", 32'(samp[1]), 32'h80);
         check("sf12_s2", 32'(samp[2]), 32'h00);
      end

      // Abort after 10 samples
      clear_mon();
      apply_cfg(4'd6, 12'd0, 1'b0, 8'd0, 7'd0, acc);
      wait_samples(10, 100);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("ab_busy", 32'(busy), 32'h0);
      check("ab_ready", 32'(cfg_ready), 32'h1);
      repeat (20) @(negedge clk);
      check("ab_count", 32'(samp.size()), 32'd10);
      check("ab_done_cnt", 32'(done_cnt), 32'd0);
      check("ab_hold", 32'(data), 32'h10);

      // Abort coinciding with the final tick
      clear_mon();
      apply_cfg(4'd6, 12'd0, 1'b0, 8'd0, 7'd0, acc);
      wait_samples(63, 200);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      repeat (20) @(negedge clk);
      check("abf_count", 32'(samp.size()), 32'd63);
      check("abf_done_cnt", 32'(done_cnt), 32'd0);
      check("abf_ready", 32'(cfg_ready), 32'h1);

      // Abort in IDLE is ignored, even across the acceptance edge
      clear_mon();
      abort = 1'b1;
      repeat (3) @(negedge clk);
      check("abi_ready", 32'(cfg_ready), 32'h1);
      apply_cfg(4'd6, 12'd0, 1'b0, 8'd0, 7'd0, acc);
      check("abi_busy", 32'(busy), 32'h1);
      abort = 1'b0;
      wait_done(1, 300);
      check("abi_count", 32'(samp.size()), 32'd64);
      check("abi_done_cnt", 32'(done_cnt), 32'd1);

      // Back-to-back with cfg_valid held high
      clear_mon();
      acc_list.delete();
      @(negedge clk);
      cfg_sf    = 4'd6;
      cfg_sym   = '0;
      cfg_down  = 1'b0;
      cfg_nsym  = 8'd0;
      cfg_div   = 7'd0;
      cfg_valid = 1'b1;
      cnt = 0;
      while (acc_list.size() < 2 && cnt < 400) begin
         #1;
         if (cfg_ready && cfg_valid) acc_list.push_back(cyc);
         if (acc_list.size() < 2) @(negedge clk);
         cnt++;
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      check("b2b_accepts", 32'(acc_list.size()), 32'd2);
      wait_done(2, 400);
      check("b2b_count", 32'(samp.size()), 32'd128);
      check("b2b_done_cnt", 32'(done_cnt), 32'd2);
      if (acc_list.size() == 2 && done_time.size() >= 1 && samp.size() == 128) begin
         check("b2b_acc_t", 32'(acc_list[1]), 32'(done_time[0]));
         check("b2b_s0", 32'(samp[64]), 32'h00);
         check("b2b_s1", 32'(samp[65]), 32'h80);
         check("b2b_first_t", 32'(vtime[64]), 32'(acc_list[1] + 2));
      end

      // Reset asserted mid-chirp
      clear_mon();
      apply_cfg(4'd6, 12'd0, 1'b0, 8'd1, 7'd0, acc);
      repeat (20) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_data",   32'(data),      32'h0);
      check("mrst_valid",  32'(valid),     32'h0);
      check("mrst_busy",   32'(busy),      32'h0);
      check("mrst_done_n", 32'(done_n),    32'h1);
      check("mrst_ready",  32'(cfg_ready), 32'h1);
      cnt = samp.size();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mrst_novalid", 32'(samp.size()), 32'(cnt));
      check("mrst_nodone", 32'(done_cnt), 32'd0);
      check("mrst_ready2", 32'(cfg_ready), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
